// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 window scheduler: FSM states,
// panel command opcodes, default panel geometry and the request rectangle layout.
package ili9341_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StCaset,
    StPaset,
    StRamwr,
    StStream,
    StDone
  } sched_state_e;

  localparam logic [7:0] CmdCaset = 8'h2A;
  localparam logic [7:0] CmdPaset = 8'h2B;
  localparam logic [7:0] CmdRamwr = 8'h2C;

  localparam int unsigned DefaultWidth  = 128;
  localparam int unsigned DefaultHeight = 128;

  // Coordinates are widened to 8 bits so x0+w and y0+h never wrap.
  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] w;
    logic [7:0] h;
  } rect_t;

  function automatic rect_t unpack_rect(input logic [27:0] r);
    return {1'b0, r[27:21], 1'b0, r[20:14], 1'b0, r[13:7], 1'b0, r[6:0]};
  endfunction

endpackage

// File: rtl/sched_rr_arb.sv
// Two-requester round-robin arbiter; the pointer moves past the winner on each grant
// so the requester not granted last wins a tie.
module sched_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;  // 1 favours requester 1

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ili9341_window_sched.sv
// Arbitrates window redraw requests and streams CASET/PASET/RAMWR plus pixel words
// to the SPI controller. Define SCHED_CLIP_EN to clip rectangles to the panel.
module ili9341_window_sched
  import ili9341_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned HEIGHT     = DefaultHeight,
  parameter int unsigned PIXEL_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [55:0]           req_rect,
  output logic [1:0]            gnt,
  output logic [13:0]           mem_addr,
  output logic                  mem_rd,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic                  out_dc,
  output logic                  out_wide,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam logic [7:0]  WidthC    = 8'(WIDTH);
  localparam logic [7:0]  HeightC   = 8'(HEIGHT);
  localparam logic [13:0] RowStride = 14'(WIDTH);

  sched_state_e state_q, state_d;
  rect_t        rect_q, rect_d;
  logic [2:0]   bcnt_q, bcnt_d;
  logic [7:0]   fx_q, fx_d, fy_q, fy_d;
  logic [15:0]  fetch_left_q, fetch_left_d, out_left_q, out_left_d;
  logic         hold_valid_q, hold_valid_d, pending_q, pending_d;
  logic [PIXEL_SIZE-1:0] hold_q, hold_d;

  logic [1:0]   arb_gnt;
  rect_t        win_rect, eff_rect;
  logic         win_empty, win_bad;
  logic         xfer, issue;
  logic [7:0]   cmd, span_lo, span_hi, cmd_byte, ax, ay;
  logic [13:0]  pix_addr;
  logic [PIXEL_SIZE-1:0] pix_word;

  sched_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (state_q == StArb),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_rect  = unpack_rect(arb_gnt[1] ? req_rect[55:28] : req_rect[27:0]);
    eff_rect  = win_rect;
    win_empty = (win_rect.w == 8'd0) || (win_rect.h == 8'd0);
    win_bad   = 1'b0;
`ifdef SCHED_CLIP_EN
    if (win_rect.x0 >= WidthC || win_rect.y0 >= HeightC) begin
      win_empty = 1'b1;
    end else begin
      if (8'(win_rect.x0 + win_rect.w) > WidthC) eff_rect.w = WidthC - win_rect.x0;
      if (8'(win_rect.y0 + win_rect.h) > HeightC) eff_rect.h = HeightC - win_rect.y0;
    end
`else
    win_bad = !win_empty && ((8'(win_rect.x0 + win_rect.w) > WidthC) ||
                             (8'(win_rect.y0 + win_rect.h) > HeightC));
`endif
  end

  // Command byte sequence: opcode, start hi/lo, end hi/lo (hi bytes are always zero).
  always_comb begin
    if (state_q == StCaset) begin
      cmd     = CmdCaset;
      span_lo = rect_q.x0;
      span_hi = rect_q.x0 + rect_q.w - 8'd1;
    end else begin
      cmd     = CmdPaset;
      span_lo = rect_q.y0;
      span_hi = rect_q.y0 + rect_q.h - 8'd1;
    end
    unique case (bcnt_q)
      3'd0:    cmd_byte = cmd;
      3'd2:    cmd_byte = span_lo;
      3'd4:    cmd_byte = span_hi;
      default: cmd_byte = 8'h00;
    endcase
  end

  assign ax       = rect_q.x0 + fx_q;
  assign ay       = rect_q.y0 + fy_q;
  assign pix_addr = {6'd0, ay} * RowStride + {6'd0, ax};
  // A word arriving from memory is offered straight away; it lands in the holding
  // register only if the controller stalls, so at most one pixel is ever in flight.
  assign pix_word = hold_valid_q ? hold_q : mem_data;

  assign xfer   = out_valid & out_ready;
  assign issue  = (state_q == StStream) && (fetch_left_q != 16'd0) &&
                  (!(hold_valid_q || pending_q) || xfer);
  assign mem_rd   = issue;
  assign mem_addr = issue ? pix_addr : 14'd0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (|req) state_d = StArb;
      StArb: begin
        if (arb_gnt == 2'b00) state_d = StIdle;
        else if (win_empty)   state_d = StDone;
        else if (win_bad)     state_d = StIdle;
        else                  state_d = StCaset;
      end
      StCaset:  if (xfer && bcnt_q == 3'd4) state_d = StPaset;
      StPaset:  if (xfer && bcnt_q == 3'd4) state_d = StRamwr;
      StRamwr:  if (xfer) state_d = StStream;
      StStream: if (xfer && out_left_q == 16'd1) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt        = 2'b00;
    err        = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != StIdle);
    out_valid  = 1'b0;
    out_data   = 16'h0000;
    out_dc     = 1'b0;
    out_wide   = 1'b0;
    unique case (state_q)
      StArb: begin
        gnt = arb_gnt;
        err = win_bad && (arb_gnt != 2'b00);
      end
      StCaset, StPaset: begin
        out_valid = 1'b1;
        out_dc    = (bcnt_q != 3'd0);
        out_data  = {8'h00, cmd_byte};
      end
      StRamwr: begin
        out_valid = 1'b1;
        out_data  = {8'h00, CmdRamwr};
      end
      StStream: begin
        out_valid = hold_valid_q || pending_q;
        out_dc    = 1'b1;
        out_wide  = 1'b1;
        out_data  = 16'(pix_word);
      end
      StDone:  frame_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rect_d       = rect_q;
    bcnt_d       = bcnt_q;
    fx_d         = fx_q;
    fy_d         = fy_q;
    fetch_left_d = fetch_left_q;
    out_left_d   = out_left_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    pending_d    = 1'b0;
    unique case (state_q)
      StArb: begin
        rect_d       = eff_rect;
        bcnt_d       = 3'd0;
        fx_d         = 8'd0;
        fy_d         = 8'd0;
        fetch_left_d = {8'd0, eff_rect.w} * {8'd0, eff_rect.h};
        out_left_d   = {8'd0, eff_rect.w} * {8'd0, eff_rect.h};
        hold_valid_d = 1'b0;
      end
      StCaset, StPaset: begin
        if (xfer) bcnt_d = (bcnt_q == 3'd4) ? 3'd0 : bcnt_q + 3'd1;
      end
      StStream: begin
        pending_d = issue;
        if (pending_q && !xfer) begin
          hold_valid_d = 1'b1;
          hold_d       = mem_data;
        end else if (xfer) begin
          hold_valid_d = 1'b0;
        end
        if (issue) begin
          fetch_left_d = fetch_left_q - 16'd1;
          if (fx_q == rect_q.w - 8'd1) begin
            fx_d = 8'd0;
            fy_d = fy_q + 8'd1;
          end else begin
            fx_d = fx_q + 8'd1;
          end
        end
        if (xfer) out_left_d = out_left_q - 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rect_q       <= '0;
      bcnt_q       <= 3'd0;
      fx_q         <= 8'd0;
      fy_q         <= 8'd0;
      fetch_left_q <= 16'd0;
      out_left_q   <= 16'd0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rect_q       <= rect_d;
      bcnt_q       <= bcnt_d;
      fx_q         <= fx_d;
      fy_q         <= fy_d;
      fetch_left_q <= fetch_left_d;
      out_left_q   <= out_left_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
    end
  end

endmodule

// File: tb/tb_ili9341_window_sched.sv
// Scoreboard bench for ili9341_window_sched: directed windows push expected words and
// grants into queues; a negedge monitor pops and compares every handshake.
module tb_ili9341_window_sched;

  localparam int W = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [55:0] req_rect;
  logic [1:0]  gnt;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_dc, out_wide, busy, frame_done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0, fd_cnt = 0, err_cnt = 0, ov_cnt = 0, last_gnt_cyc = 0, last_fd_cyc = 0;
  logic [17:0] exp_q[$];
  logic [1:0]  gnt_q[$];
  logic        stall_q = 1'b0;
  logic [18:0] stall_word = '0;

  always #5 clk = ~clk;

  ili9341_window_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_rect   (req_rect),
    .gnt        (gnt),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_dc     (out_dc),
    .out_wide   (out_wide),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  function automatic logic [15:0] pix(input logic [13:0] a);
    return {2'b11, a};
  endfunction

  // Memory model: data is valid exactly one cycle after the read strobe.
  always @(posedge clk) mem_data <= mem_rd ? pix(mem_addr) : 16'h0BAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("stall_hold", 32'({out_valid, out_dc, out_wide, out_data}), 32'(stall_word));
      if (gnt != 2'b00) begin
        last_gnt_cyc = cyc;
        if (gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'h0);
        else check("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
      end
      if (frame_done) begin
        fd_cnt++;
        last_fd_cyc = cyc;
      end
      if (err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          check("word_unexpected", 32'({out_dc, out_wide, out_data}), 32'hFFFF_FFFF);
        else
          check("word", 32'({out_dc, out_wide, out_data}), 32'(exp_q.pop_front()));
      end
      stall_q    = out_valid && !out_ready;
      stall_word = {out_valid, out_dc, out_wide, out_data};
    end
  end

  task automatic set_rect(input int r, input int x0, input int y0, input int w, input int h);
    req_rect[r*28 +: 28] = {7'(x0), 7'(y0), 7'(w), 7'(h)};
  endtask

  task automatic push_byte(input logic dc, input int b);
    exp_q.push_back({dc, 1'b0, 8'h00, 8'(b)});
  endtask

  task automatic push_window(input int x0, input int y0, input int w, input int h);
    int x1, y1;
    x1 = x0 + w - 1;
    y1 = y0 + h - 1;
    push_byte(1'b0, 'h2A);
    push_byte(1'b1, x0 >> 8); push_byte(1'b1, x0 & 255);
    push_byte(1'b1, x1 >> 8); push_byte(1'b1, x1 & 255);
    push_byte(1'b0, 'h2B);
    push_byte(1'b1, y0 >> 8); push_byte(1'b1, y0 & 255);
    push_byte(1'b1, y1 >> 8); push_byte(1'b1, y1 & 255);
    push_byte(1'b0, 'h2C);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        exp_q.push_back({1'b1, 1'b1, pix(14'((y0 + j) * W + x0 + i))});
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 60);
    if (gnt == 2'b00) fail_now({name, "_gnt_timeout"});
  endtask

  task automatic release_req();
    @(posedge clk);
    #1 req = 2'b00;
  endtask

  task automatic wait_frames(input int target, input bit toggle, input string name);
    int n;
    n = 0;
    while (fd_cnt < target && n < 400) begin
      @(posedge clk);
      #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    if (fd_cnt < target) fail_now({name, "_frame_timeout"});
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    gnt_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, e0, k;
    rst = 1'b1;
    req = 2'b00;
    req_rect = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_pulses", 32'({gnt, frame_done, err, mem_rd}), 32'h0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic 2x2 window at the origin.
    set_rect(0, 0, 0, 2, 2);
    gnt_q.push_back(2'b01);
    push_window(0, 0, 2, 2);
    req = 2'b01;
    wait_gnt("t1");
    release_req();
    wait_frames(1, 1'b0, "t1");
    check("t1_gnt_to_done", 32'(last_fd_cyc - last_gnt_cyc), 32'd17);
    check("t1_frames", 32'(fd_cnt), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t1_idle", 32'(busy), 32'h0);

    // Round robin: 11 held through two windows, then 10 followed by 11.
    do_reset();
    set_rect(0, 10, 3, 1, 1);
    set_rect(1, 20, 4, 1, 2);
    gnt_q.push_back(2'b01); push_window(10, 3, 1, 1);
    gnt_q.push_back(2'b10); push_window(20, 4, 1, 2);
    req = 2'b11;
    wait_gnt("t2a");
    wait_gnt("t2b");
    release_req();
    wait_frames(3, 1'b0, "t2");
    check("t2_sb_empty", 32'(exp_q.size() + gnt_q.size()), 32'd0);
    gnt_q.push_back(2'b10); push_window(20, 4, 1, 2);
    gnt_q.push_back(2'b01); push_window(10, 3, 1, 1);
    req = 2'b10;
    wait_gnt("t2c");
    @(posedge clk);
    #1 req = 2'b11;
    wait_gnt("t2d");
    release_req();
    wait_frames(5, 1'b0, "t2");
    check("t2_sb_empty2", 32'(exp_q.size() + gnt_q.size()), 32'd0);

    // Backpressure: out_ready toggles every cycle.
    set_rect(0, 3, 2, 3, 2);
    gnt_q.push_back(2'b01);
    push_window(3, 2, 3, 2);
    out_ready = 1'b0;
    req = 2'b01;
    wait_gnt("t3");
    release_req();
    wait_frames(6, 1'b1, "t3");
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Rectangle running off the right edge.
    set_rect(0, 120, 0, 16, 1);
    gnt_q.push_back(2'b01);
    e0 = err_cnt;
    o0 = ov_cnt;
    f0 = fd_cnt;
`ifdef SCHED_CLIP_EN
    push_window(120, 0, 8, 1);
    req = 2'b01;
    wait_gnt("t4");
    release_req();
    wait_frames(f0 + 1, 1'b0, "t4");
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t4_no_err", 32'(err_cnt), 32'(e0));
`else
    req = 2'b01;
    wait_gnt("t4");
    check("t4_err_with_gnt", 32'(err), 32'h1);
    release_req();
    repeat (5) @(negedge clk);
    check("t4_idle", 32'(busy), 32'h0);
    check("t4_no_out_valid", 32'(ov_cnt), 32'(o0));
    check("t4_no_frame_done", 32'(fd_cnt), 32'(f0));
    check("t4_one_err", 32'(err_cnt), 32'(e0 + 1));
`endif

    // Empty rectangle: grant then frame_done on the following cycle.
    set_rect(0, 5, 5, 0, 3);
    gnt_q.push_back(2'b01);
    e0 = err_cnt;
    o0 = ov_cnt;
    req = 2'b01;
    wait_gnt("t5");
    release_req();
    @(negedge clk);
    check("t5_frame_done", 32'(frame_done), 32'h1);
    repeat (3) @(negedge clk);
    check("t5_no_out_valid", 32'(ov_cnt), 32'(o0));
    check("t5_no_err", 32'(err_cnt), 32'(e0));
    check("t5_idle", 32'(busy), 32'h0);

    // Reset on the third pixel aborts the window; a new request restarts at CASET.
    set_rect(0, 0, 0, 4, 1);
    gnt_q.push_back(2'b01);
    push_window(0, 0, 4, 1);
    req = 2'b01;
    wait_gnt("t6");
    release_req();
    k = 0;
    for (int n = 0; n < 100 && k < 3; n++) begin
      @(negedge clk);
      if (out_valid && out_wide && out_ready) k++;
    end
    if (k < 3) fail_now("t6_third_pixel");
    f0 = fd_cnt;
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_busy_after_rst", 32'(busy), 32'h0);
    check("t6_valid_after_rst", 32'(out_valid), 32'h0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("t6_no_frame_done", 32'(fd_cnt), 32'(f0));
    set_rect(0, 1, 1, 1, 1);
    gnt_q.push_back(2'b01);
    push_window(1, 1, 1, 1);
    @(posedge clk);
    #1 req = 2'b01;
    wait_gnt("t6b");
    release_req();
    wait_frames(f0 + 1, 1'b0, "t6b");
    check("t6_sb_empty", 32'(exp_q.size() + gnt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
